// File: rtl/dead_pixel_table.sv
// dead_pixel_table
// Dead-pixel coordinate table for the thermal readout path. Entries are
// loaded from EEPROM calibration data and looked up by a sequential scan
// that stops at the first valid matching entry. The lowest index wins when
// coordinates are duplicated.
module dead_pixel_table #(
    parameter int X_W   = 7,
    parameter int Y_W   = 6,
    parameter int DEPTH = 24,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic             wr_valid,
    input  logic             clr_all,
    input  logic             lk_req,
    input  logic [X_W-1:0]   lk_x,
    input  logic [Y_W-1:0]   lk_y,
    output logic             lk_busy,
    output logic             lk_done,
    output logic             lk_hit,
    output logic [IDX_W-1:0] lk_idx,
    output logic [IDX_W:0]   count
);

    // Index of the last entry; the scan ends with a miss after comparing it.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    // Table depth at the width of count, for the write range check.
    localparam logic [IDX_W:0]   DEPTH_W  = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Entry matches only when it is valid and both coordinates are equal.
    function automatic logic coord_match(
        input logic           entry_valid,
        input logic [X_W-1:0] entry_x,
        input logic [Y_W-1:0] entry_y,
        input logic [X_W-1:0] key_x,
        input logic [Y_W-1:0] key_y
    );
        return entry_valid && (entry_x == key_x) && (entry_y == key_y);
    endfunction

    // Table storage; coordinates are deliberately not reset.
    logic             valid_r [DEPTH];
    logic [X_W-1:0]   x_r     [DEPTH];
    logic [Y_W-1:0]   y_r     [DEPTH];
    logic [IDX_W:0]   count_r;

    // Lookup engine state.
    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] scan_idx_r;
    logic [IDX_W-1:0] scan_idx_nxt_s;
    logic [X_W-1:0]   key_x_r;
    logic [X_W-1:0]   key_x_nxt_s;
    logic [Y_W-1:0]   key_y_r;
    logic [Y_W-1:0]   key_y_nxt_s;
    logic             hit_r;
    logic             hit_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;

    logic             wr_in_range_s;
    logic             wr_apply_s;
    logic [IDX_W:0]   count_nxt_s;
    logic             entry_match_s;

    // Out-of-range writes are dropped; a bulk clear overrides any write.
    always_comb begin
        wr_in_range_s = ({1'b0, wr_idx} < DEPTH_W);
        wr_apply_s    = wr_en && wr_in_range_s && !clr_all;
    end

    // Occupancy changes only when an entry's valid bit actually flips.
    always_comb begin
        count_nxt_s = count_r;
        if (wr_apply_s) begin
            if (wr_valid && !valid_r[wr_idx]) begin
                count_nxt_s = count_r + (IDX_W + 1)'(1);
            end else if (!wr_valid && valid_r[wr_idx]) begin
                count_nxt_s = count_r - (IDX_W + 1)'(1);
            end else begin
                count_nxt_s = count_r;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Valid bits and occupancy count, cleared by reset or bulk clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
            end
            count_r <= {(IDX_W + 1){1'b0}};
        end else if (clr_all) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
            end
            count_r <= {(IDX_W + 1){1'b0}};
        end else begin
            if (wr_apply_s) begin
                valid_r[wr_idx] <= wr_valid;
            end
            count_r <= count_nxt_s;
        end
    end

    // Coordinate storage; invalidating writes leave the old coordinate.
    always_ff @(posedge clk) begin
        if (wr_apply_s && wr_valid) begin
            x_r[wr_idx] <= wr_x;
            y_r[wr_idx] <= wr_y;
        end
    end

    // Compare the entry under the scan pointer against the latched key,
    // using table contents registered before this edge.
    always_comb begin
        entry_match_s = coord_match(valid_r[scan_idx_r], x_r[scan_idx_r],
                                    y_r[scan_idx_r], key_x_r, key_y_r);
    end

    // Scan FSM next-state and result computation.
    always_comb begin
        state_nxt_s    = state_r;
        scan_idx_nxt_s = scan_idx_r;
        key_x_nxt_s    = key_x_r;
        key_y_nxt_s    = key_y_r;
        hit_nxt_s      = hit_r;
        idx_nxt_s      = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (lk_req) begin
                    state_nxt_s    = ST_SCAN;
                    key_x_nxt_s    = lk_x;
                    key_y_nxt_s    = lk_y;
                    scan_idx_nxt_s = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (entry_match_s) begin
                    hit_nxt_s   = 1'b1;
                    idx_nxt_s   = scan_idx_r;
                    state_nxt_s = ST_DONE;
                end else if (scan_idx_r == LAST_IDX) begin
                    hit_nxt_s   = 1'b0;
                    idx_nxt_s   = {IDX_W{1'b0}};
                    state_nxt_s = ST_DONE;
                end else begin
                    scan_idx_nxt_s = scan_idx_r + IDX_W'(1);
                    state_nxt_s    = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Scan FSM registers; reset abandons any scan without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            scan_idx_r <= {IDX_W{1'b0}};
            key_x_r    <= {X_W{1'b0}};
            key_y_r    <= {Y_W{1'b0}};
            hit_r      <= 1'b0;
            idx_r      <= {IDX_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            scan_idx_r <= scan_idx_nxt_s;
            key_x_r    <= key_x_nxt_s;
            key_y_r    <= key_y_nxt_s;
            hit_r      <= hit_nxt_s;
            idx_r      <= idx_nxt_s;
        end
    end

    assign lk_busy = (state_r != ST_IDLE);
    assign lk_done = (state_r == ST_DONE);
    assign lk_hit  = hit_r;
    assign lk_idx  = idx_r;
    assign count   = count_r;

endmodule

// File: tb/tb_dead_pixel_table.sv
// Directed testbench for dead_pixel_table (default parameters).
module tb_dead_pixel_table;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_idx = 5'd0;
    logic [6:0] wr_x = 7'd0;
    logic [5:0] wr_y = 6'd0;
    logic       wr_valid = 1'b0;
    logic       clr_all = 1'b0;
    logic       lk_req = 1'b0;
    logic [6:0] lk_x = 7'd0;
    logic [5:0] lk_y = 6'd0;
    logic       lk_busy;
    logic       lk_done;
    logic       lk_hit;
    logic [4:0] lk_idx;
    logic [5:0] count;

    int vec_n = 0;
    int err_n = 0;

    dead_pixel_table #(.X_W(7), .Y_W(6), .DEPTH(24), .IDX_W(5)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .wr_valid(wr_valid), .clr_all(clr_all),
        .lk_req(lk_req), .lk_x(lk_x), .lk_y(lk_y),
        .lk_busy(lk_busy), .lk_done(lk_done), .lk_hit(lk_hit),
        .lk_idx(lk_idx), .count(count)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input int x, input int y, input logic v);
        wr_en = 1'b1; wr_idx = 5'(idx); wr_x = 7'(x); wr_y = 6'(y); wr_valid = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic clear_table();
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
    endtask

    // Issue a request; cycle 1 is the cycle after acceptance. Returns the
    // done cycle (-1 on timeout), result and busy-cycle count, and leaves the
    // bench in the first cycle after the done cycle.
    task automatic run_lookup(input int x, input int y, output int done_cyc,
                              output logic hit, output logic [4:0] idx,
                              output int busy_n);
        lk_x = 7'(x); lk_y = 6'(y); lk_req = 1'b1;
        tick();
        lk_req = 1'b0;
        done_cyc = -1; busy_n = 0; hit = 1'bx; idx = 5'bx;
        for (int c = 1; c <= 200; c++) begin
            if (lk_busy) busy_n++;
            if (lk_done) begin
                done_cyc = c; hit = lk_hit; idx = lk_idx;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        vec_n++; if (lk_busy !== 1'b0) begin err_n++; $display("FAIL reset_busy got %b want 0", lk_busy); end
        vec_n++; if (lk_done !== 1'b0) begin err_n++; $display("FAIL reset_done got %b want 0", lk_done); end
        vec_n++; if (lk_hit !== 1'b0) begin err_n++; $display("FAIL reset_hit got %b want 0", lk_hit); end
        vec_n++; if (lk_idx !== 5'd0) begin err_n++; $display("FAIL reset_idx got %0d want 0", lk_idx); end
        vec_n++; if (count !== 6'd0) begin err_n++; $display("FAIL reset_count got %0d want 0", count); end
    endtask

    task automatic test_single_hit();
        int dc, bn; logic h; logic [4:0] ix;
        wr(3, 10, 5, 1'b1);
        vec_n++; if (count !== 6'd1) begin err_n++; $display("FAIL hit_count got %0d want 1", count); end
        run_lookup(10, 5, dc, h, ix, bn);
        vec_n++; if (dc !== 5) begin err_n++; $display("FAIL hit_done_cycle got %0d want 5", dc); end
        vec_n++; if (h !== 1'b1) begin err_n++; $display("FAIL hit_flag got %b want 1", h); end
        vec_n++; if (ix !== 5'd3) begin err_n++; $display("FAIL hit_idx got %0d want 3", ix); end
        vec_n++; if (lk_busy !== 1'b0) begin err_n++; $display("FAIL hit_busy_after got %b want 0", lk_busy); end
        vec_n++; if (lk_done !== 1'b0) begin err_n++; $display("FAIL hit_done_width got %b want 0", lk_done); end
    endtask

    task automatic test_full_miss();
        int dc, bn; logic h; logic [4:0] ix;
        clear_table();
        for (int i = 0; i < 24; i++) wr(i, i, i + 1, 1'b1);
        vec_n++; if (count !== 6'd24) begin err_n++; $display("FAIL full_count got %0d want 24", count); end
        run_lookup(99, 63, dc, h, ix, bn);
        vec_n++; if (dc !== 25) begin err_n++; $display("FAIL miss_done_cycle got %0d want 25", dc); end
        vec_n++; if (h !== 1'b0) begin err_n++; $display("FAIL miss_flag got %b want 0", h); end
        vec_n++; if (ix !== 5'd0) begin err_n++; $display("FAIL miss_idx got %0d want 0", ix); end
        vec_n++; if (bn !== 25) begin err_n++; $display("FAIL miss_busy_cycles got %0d want 25", bn); end
        vec_n++; if (lk_busy !== 1'b0) begin err_n++; $display("FAIL miss_busy_after got %b want 0", lk_busy); end
        run_lookup(23, 24, dc, h, ix, bn);
        vec_n++; if (dc !== 25 || h !== 1'b1 || ix !== 5'd23) begin
            err_n++; $display("FAIL last_entry_hit got cyc=%0d hit=%b idx=%0d want 25 1 23", dc, h, ix); end
    endtask

    task automatic test_duplicate();
        int dc, bn; logic h; logic [4:0] ix;
        clear_table();
        wr(7, 40, 20, 1'b1);
        wr(2, 40, 20, 1'b1);
        vec_n++; if (count !== 6'd2) begin err_n++; $display("FAIL dup_count got %0d want 2", count); end
        run_lookup(40, 20, dc, h, ix, bn);
        vec_n++; if (dc !== 4 || h !== 1'b1 || ix !== 5'd2) begin
            err_n++; $display("FAIL dup_lowest got cyc=%0d hit=%b idx=%0d want 4 1 2", dc, h, ix); end
        wr(2, 0, 0, 1'b0);
        vec_n++; if (count !== 6'd1) begin err_n++; $display("FAIL inval_count got %0d want 1", count); end
        run_lookup(40, 20, dc, h, ix, bn);
        vec_n++; if (dc !== 9 || h !== 1'b1 || ix !== 5'd7) begin
            err_n++; $display("FAIL inval_next got cyc=%0d hit=%b idx=%0d want 9 1 7", dc, h, ix); end
    endtask

    task automatic test_clear_and_range();
        int dc, bn; logic h; logic [4:0] ix;
        wr(0, 1, 1, 1'b1);
        clr_all = 1'b1;
        wr(5, 33, 11, 1'b1);
        clr_all = 1'b0;
        vec_n++; if (count !== 6'd0) begin err_n++; $display("FAIL clr_prio_count got %0d want 0", count); end
        run_lookup(33, 11, dc, h, ix, bn);
        vec_n++; if (dc !== 25 || h !== 1'b0) begin
            err_n++; $display("FAIL clr_prio_lookup got cyc=%0d hit=%b want 25 0", dc, h); end
        wr(1, 2, 2, 1'b1);
        wr(30, 33, 11, 1'b1);
        vec_n++; if (count !== 6'd1) begin err_n++; $display("FAIL range_count got %0d want 1", count); end
        wr(1, 2, 2, 1'b1);
        wr(4, 0, 0, 1'b0);
        vec_n++; if (count !== 6'd1) begin err_n++; $display("FAIL noflip_count got %0d want 1", count); end
    endtask

    task automatic test_busy_and_reset();
        int dn, dc; logic h; logic [4:0] ix;
        wr(10, 50, 30, 1'b1);
        lk_x = 7'd50; lk_y = 6'd30; lk_req = 1'b1;
        tick();
        dn = 0; dc = -1; h = 1'bx; ix = 5'bx;
        for (int c = 1; c <= 40; c++) begin
            if (lk_done) begin
                dn++;
                if (dc < 0) begin dc = c; h = lk_hit; ix = lk_idx; end
            end
            if (c == 3) begin lk_x = 7'd2; lk_y = 6'd2; lk_req = 1'b1; end
            else lk_req = 1'b0;
            tick();
        end
        vec_n++; if (dn !== 1) begin err_n++; $display("FAIL busy_ignore_pulses got %0d want 1", dn); end
        vec_n++; if (dc !== 12 || h !== 1'b1 || ix !== 5'd10) begin
            err_n++; $display("FAIL busy_ignore_result got cyc=%0d hit=%b idx=%0d want 12 1 10", dc, h, ix); end
        lk_x = 7'd99; lk_y = 6'd63; lk_req = 1'b1;
        tick();
        lk_req = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec_n++; if ({lk_busy, lk_done, lk_hit, lk_idx} !== 8'd0) begin
            err_n++; $display("FAIL abort_outputs got busy=%b done=%b hit=%b idx=%0d want all 0", lk_busy, lk_done, lk_hit, lk_idx); end
        vec_n++; if (count !== 6'd0) begin err_n++; $display("FAIL abort_count got %0d want 0", count); end
        dn = 0;
        for (int c = 0; c < 30; c++) begin
            if (lk_done) dn++;
            tick();
        end
        vec_n++; if (dn !== 0) begin err_n++; $display("FAIL abort_no_done got %0d want 0", dn); end
        run_lookup(50, 30, dc, h, ix, dn);
        vec_n++; if (dc !== 25 || h !== 1'b0) begin
            err_n++; $display("FAIL abort_valid_cleared got cyc=%0d hit=%b want 25 0", dc, h); end
    endtask

    // Lookup of (70,40) with an entry written while the scan sits at idx 4.
    task automatic scan_with_write(input int widx, output int dc, output logic h,
                                   output logic [4:0] ix);
        clear_table();
        lk_x = 7'd70; lk_y = 6'd40; lk_req = 1'b1;
        tick();
        lk_req = 1'b0;
        dc = -1; h = 1'bx; ix = 5'bx;
        for (int c = 1; c <= 60; c++) begin
            if (lk_done) begin dc = c; h = lk_hit; ix = lk_idx; break; end
            if (c == 5) begin
                wr_en = 1'b1; wr_idx = 5'(widx); wr_x = 7'd70; wr_y = 6'd40; wr_valid = 1'b1;
            end else wr_en = 1'b0;
            tick();
        end
        wr_en = 1'b0;
        tick();
    endtask

    task automatic test_scan_write();
        int dc; logic h; logic [4:0] ix;
        scan_with_write(4, dc, h, ix);
        vec_n++; if (dc !== 25 || h !== 1'b0) begin
            err_n++; $display("FAIL write_current_unseen got cyc=%0d hit=%b want 25 0", dc, h); end
        vec_n++; if (count !== 6'd1) begin err_n++; $display("FAIL write_during_scan_count got %0d want 1", count); end
        scan_with_write(9, dc, h, ix);
        vec_n++; if (dc !== 11 || h !== 1'b1 || ix !== 5'd9) begin
            err_n++; $display("FAIL write_ahead_seen got cyc=%0d hit=%b idx=%0d want 11 1 9", dc, h, ix); end
    endtask

    task automatic test_back_to_back();
        int dc, c; logic h; logic [4:0] ix; int dn;
        clear_table();
        wr(1, 5, 6, 1'b1);
        lk_x = 7'd5; lk_y = 6'd6; lk_req = 1'b1;
        tick();
        dn = 0; dc = -1;
        for (c = 1; c <= 20; c++) begin
            if (lk_done) begin
                dn++;
                if (dn == 2) begin dc = c; h = lk_hit; ix = lk_idx; break; end
            end
            tick();
        end
        lk_req = 1'b0;
        tick(); tick();
        vec_n++; if (dc !== 7 || h !== 1'b1 || ix !== 5'd1) begin
            err_n++; $display("FAIL back_to_back got cyc=%0d hit=%b idx=%0d want 7 1 1", dc, h, ix); end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_full_miss();
        test_duplicate();
        test_clear_and_range();
        test_busy_and_reset();
        test_scan_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule

// File: doc/dead_pixel_table.md
# dead_pixel_table

Parametrised dead-pixel lookup table for the thermal sensor readout path. Holds up to DEPTH defective-pixel coordinates with per-entry valid bits, loaded from EEPROM calibration data, and answers coordinate lookups with a sequential scan FSM. Each lookup returns a hit/miss flag and the matching entry index through a request/done handshake. It sits between the EEPROM loader and the pixel-correction stage. Compared with the fixed 24-entry comparator, it adds per-entry valid/clear, a bulk clear, an occupancy count and deterministic early-terminating scans.

## Interface
Parameters:
- X_W, 7, pixel column width
- Y_W, 6, pixel row width
- DEPTH, 24, number of table entries (2..256)
- IDX_W, 5, index width; must equal ceil(log2(DEPTH))

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe for one table entry
- wr_idx  in  IDX_W  entry index to write
- wr_x  in  X_W  column of the dead pixel
- wr_y  in  Y_W  row of the dead pixel
- wr_valid  in  1  1 = store the coordinate and mark the entry valid; 0 = invalidate the entry
- clr_all  in  1  invalidate all entries
- lk_req  in  1  lookup request; sampled only when lk_busy=0
- lk_x  in  X_W  lookup column; latched on request acceptance
- lk_y  in  Y_W  lookup row; latched on request acceptance
- lk_busy  out  1  high while a lookup is in progress
- lk_done  out  1  one-cycle pulse when the result is valid
- lk_hit  out  1  1 = a valid entry matched
- lk_idx  out  IDX_W  index of the matching entry; 0 on a miss
- count  out  IDX_W+1  number of valid entries

## Operation
- Storage: DEPTH entries, each holding {valid, x, y}.
- Write (wr_en=1, wr_idx<DEPTH): at the clock edge, entry[wr_idx] takes x/y and valid<=wr_valid.
  - wr_idx>=DEPTH: the write is ignored.
  - wr_valid=0: clears only the valid bit; x/y are don't-care.
- clr_all=1: all valid bits cleared at the edge. clr_all takes priority over a simultaneous wr_en.
- count: tracks valid entries and updates on the same edge as the table change.
  - Rewriting a valid entry with valid=1, or invalidating an invalid entry, leaves count unchanged.
  - After clr_all, count=0.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: on lk_req=1, latch lk_x/lk_y, set scan index to 0, go to SCAN.
  - SCAN: compare entry[idx] against the latched coordinate.
    - Valid and exact match on both x and y: lk_hit<=1, lk_idx<=idx, go to DONE.
    - No match and idx==DEPTH-1: lk_hit<=0, lk_idx<=0, go to DONE.
    - Otherwise: idx<=idx+1 and remain in SCAN.
  - DONE: lk_done=1 for exactly this cycle, then go to IDLE.
- Duplicate coordinates in the table: the lowest index wins.
- lk_busy = (state != IDLE). lk_req is ignored while busy; there is no request queue.
- lk_hit/lk_idx hold their values from DONE until the next accepted request enters SCAN. While SCAN is in progress they are not meaningful.
- Writes and clears are allowed during a scan. The compare in a given cycle uses the table contents registered before that edge, so a same-cycle write to the entry being compared is not seen.
- Reset (rst=1, any state, including mid-scan):
  - all valid bits cleared, count=0, state=IDLE;
  - lk_busy=0, lk_done=0, lk_hit=0, lk_idx=0;
  - an aborted scan produces no lk_done.
  - x/y storage is not reset.

## Timing
- lk_req high in cycle 0 (accepted): lk_busy=1 from cycle 1.
- Hit at entry k: SCAN occupies cycles 1..k+1; lk_done=1 in cycle k+2; lk_busy=0 from cycle k+3.
- Miss: lk_done in cycle DEPTH+1; lk_busy=0 from cycle DEPTH+2.
- Back-to-back: lk_req held high continuously is accepted again in the first IDLE cycle, i.e. the cycle after DONE.
- Write latency: one cycle. An entry written at edge n is visible to a compare in cycle n+1 onward.
- All outputs are registered. lk_busy is decoded directly from the state register.

## Test plan
- Reset, then write idx3=(10,5) valid; request (10,5) in cycle 0 -> lk_done in cycle 5, lk_hit=1, lk_idx=3, count=1.
- Table loaded with 24 distinct entries; request (99,63), which is absent -> lk_done in cycle 25, lk_hit=0, lk_idx=0, lk_busy high in cycles 1..25.
- Same coordinate written at idx7 and idx2 -> hit reports lk_idx=2. Invalidate idx2 (wr_valid=0) -> next lookup reports lk_idx=7; count goes 2 -> 1.
- wr_en with wr_idx=5 and clr_all in the same cycle -> count=0, and a lookup of that coordinate misses. Write with wr_idx=30 -> ignored, count unchanged.
- lk_req pulsed in cycle 3 during an active scan -> ignored, exactly one lk_done. Assert rst at cycle 4 of a scan -> outputs zero, no lk_done, all valid bits cleared.
- During a scan at idx=4, write entry 4 with the lookup coordinate -> not matched that pass. Write entry 9 instead -> hit with lk_idx=9.
